// File: rtl/fp_cmp_arbiter.sv
// Round-robin arbiter in front of a single shared single-precision compare unit.
// Supports FEQ/FLT/FLE (func3 010/001/000) and returns a tagged result over valid/ready.
// It also keeps a sticky invalid-operation flag for fflags.
module fp_cmp_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [32*NUM_REQ-1:0]  req_a,
  input  logic [32*NUM_REQ-1:0]  req_b,
  input  logic [3*NUM_REQ-1:0]   req_func3,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic                   rsp_cmp,
  output logic                   rsp_invalid,
  output logic                   fflags_nv,
  input  logic                   fflags_clr,
  output logic                   busy
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e          state_q;
  logic [ID_W-1:0] rr_ptr_q;
  logic [31:0]     op_a_q;
  logic [31:0]     op_b_q;
  logic [2:0]      op_func3_q;
  logic [ID_W-1:0] op_id_q;

  logic            grant_found;
  logic [ID_W-1:0] grant_id;

  // First valid requester scanning upward from rr_ptr, wrapping modulo NUM_REQ
  always_comb begin
    int              idx;
    logic [ID_W-1:0] cand;
    grant_found = 1'b0;
    grant_id    = '0;
    idx         = 0;
    cand        = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= int'(NUM_REQ)) idx = idx - int'(NUM_REQ);
      cand = ID_W'(idx);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_id    = cand;
      end
    end
  end

  // Grant is only offered while idle; held off during reset
  always_comb begin
    req_ready = '0;
    if (!rst && state_q == StIdle && grant_found) req_ready[grant_id] = 1'b1;
  end

  assign busy = (state_q != StIdle);

  logic a_nan, b_nan, a_snan, b_snan, any_nan, both_zero;
  logic is_eq, is_lt, cmp_res, cmp_inv;

  // Sign-magnitude compare on the latched operands; NaNs never compare true
  always_comb begin
    a_nan     = (&op_a_q[30:23]) && (|op_a_q[22:0]);
    b_nan     = (&op_b_q[30:23]) && (|op_b_q[22:0]);
    a_snan    = a_nan && !op_a_q[22];
    b_snan    = b_nan && !op_b_q[22];
    any_nan   = a_nan || b_nan;
    both_zero = ~|(op_a_q[30:0] | op_b_q[30:0]);
    is_eq     = !any_nan && ((op_a_q == op_b_q) || both_zero);
    if (any_nan || both_zero) begin
      is_lt = 1'b0;
    end else if (op_a_q[31] != op_b_q[31]) begin
      is_lt = op_a_q[31];
    end else if (!op_a_q[31]) begin
      is_lt = op_a_q[30:0] < op_b_q[30:0];
    end else begin
      is_lt = op_a_q[30:0] > op_b_q[30:0];
    end
    case (op_func3_q)
      3'b010:  cmp_res = is_eq;
      3'b001:  cmp_res = is_lt;
      3'b000:  cmp_res = is_lt || is_eq;
      default: cmp_res = 1'b0;
    endcase
    cmp_inv = a_snan || b_snan;
  end

  // Control FSM with registered response outputs and sticky NV
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_func3_q  <= '0;
      op_id_q     <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_cmp     <= 1'b0;
      rsp_invalid <= 1'b0;
      fflags_nv   <= 1'b0;
    end else begin
      // Clear first so a same-cycle set below takes priority
      if (fflags_clr) fflags_nv <= 1'b0;
      case (state_q)
        StIdle: begin
          if (grant_found) begin
            op_a_q     <= req_a[32*grant_id +: 32];
            op_b_q     <= req_b[32*grant_id +: 32];
            op_func3_q <= req_func3[3*grant_id +: 3];
            op_id_q    <= grant_id;
            state_q    <= StExec;
          end
        end
        StExec: begin
          rsp_cmp     <= cmp_res;
          rsp_invalid <= cmp_inv;
          rsp_id      <= op_id_q;
          rsp_valid   <= 1'b1;
          if (cmp_inv) fflags_nv <= 1'b1;
          state_q     <= StResp;
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rr_ptr_q  <= (rsp_id == ID_W'(NUM_REQ - 1)) ? '0 : rsp_id + 1'b1;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
